// File: rtl/rv32_mem_pkg.sv
// Shared types and helpers for the RV32 block-RAM memory controller.
// Holds the FSM state type, data widths and the halfword byte-merge.
package rv32_mem_pkg;

  localparam int HALF_W = 16;
  localparam int XLEN   = 32;

  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    RD_HI,
    RD_CAP,
    WR_LO,
    MRG_LO,
    WR_HI,
    MRG_HI,
    RSP
  } state_e;

  function automatic logic [HALF_W-1:0] merge_half(
    input logic [HALF_W-1:0] old16,
    input logic [HALF_W-1:0] new16,
    input logic [1:0]        strb2
  );
    logic [HALF_W-1:0] r;
    r[7:0]  = strb2[0] ? new16[7:0]  : old16[7:0];
    r[15:8] = strb2[1] ? new16[15:8] : old16[15:8];
    return r;
  endfunction

endpackage

// File: rtl/rv32_bram_mem_ctrl.sv
// Word-request controller over one 16-bit block RAM: two halfword
// accesses per word, read-modify-write for partial halfword stores.
module rv32_bram_mem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int HALF_AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_wstrb,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               bram_wen,
  output logic [HALF_AW-1:0] bram_waddr,
  output logic [15:0]        bram_wdata,
  output logic               bram_ren,
  output logic [HALF_AW-1:0] bram_raddr,
  input  logic [15:0]        bram_rdata
);
  import rv32_mem_pkg::*;

  localparam int WAW = HALF_AW - 1;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [WAW-1:0]    widx_q, widx_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [HALF_W-1:0] lo_q, lo_d;
  logic [HALF_W-1:0] hi_q, hi_d;

  logic [HALF_AW-1:0] lo_addr, hi_addr;
  logic               unused_addr;

  assign lo_addr = {widx_q, 1'b0};
  assign hi_addr = {widx_q, 1'b1};
  assign unused_addr = ^{req_addr[31:HALF_AW+1], req_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    widx_d     = widx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = '0;
    bram_wen   = 1'b0;
    bram_waddr = '0;
    bram_wdata = '0;
    bram_ren   = 1'b0;
    bram_raddr = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          widx_d  = req_addr[HALF_AW:2];
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          state_d = req_we ? WR_LO : RD_LO;
        end
      end
      RD_LO: begin
        bram_ren   = 1'b1;
        bram_raddr = lo_addr;
        state_d    = RD_HI;
      end
      RD_HI: begin
        bram_ren   = 1'b1;
        bram_raddr = hi_addr;
        lo_d       = bram_rdata;
        state_d    = RD_CAP;
      end
      RD_CAP: begin
        hi_d    = bram_rdata;
        state_d = RSP;
      end
      WR_LO: begin
        state_d = WR_HI;
        if (wstrb_q[1:0] == 2'b11) begin
          bram_wen   = 1'b1;
          bram_waddr = lo_addr;
          bram_wdata = wdata_q[15:0];
        end else if (wstrb_q[1:0] != 2'b00) begin
          bram_ren   = 1'b1;
          bram_raddr = lo_addr;
          state_d    = MRG_LO;
        end
      end
      MRG_LO: begin
        bram_wen   = 1'b1;
        bram_waddr = lo_addr;
        bram_wdata = merge_half(bram_rdata, wdata_q[15:0], wstrb_q[1:0]);
        state_d    = WR_HI;
      end
      WR_HI: begin
        state_d = RSP;
        if (wstrb_q[3:2] == 2'b11) begin
          bram_wen   = 1'b1;
          bram_waddr = hi_addr;
          bram_wdata = wdata_q[31:16];
        end else if (wstrb_q[3:2] != 2'b00) begin
          bram_ren   = 1'b1;
          bram_raddr = hi_addr;
          state_d    = MRG_HI;
        end
      end
      MRG_HI: begin
        bram_wen   = 1'b1;
        bram_waddr = hi_addr;
        bram_wdata = merge_half(bram_rdata, wdata_q[31:16], wstrb_q[3:2]);
        state_d    = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        rsp_rdata = we_q ? '0 : {hi_q, lo_q};
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule
